// File: rtl/png_to_binary.sv
// Re-expands a decimated pixel stream: each input pixel becomes REPEAT outputs,
// held by default or linearly interpolated when PNG_TO_BINARY_INTERP_EN is defined.
module png_to_binary #(
  parameter int REPEAT     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] png_pixel,
  input  logic       png_valid,
  output logic       png_ready,
  output logic [7:0] binary_pixel,
  output logic       binary_valid,
  input  logic       binary_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [3:0]    KMAX    = 4'(REPEAT);

  typedef enum logic {IDLE, EMIT} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          png_ready_reg;
  logic          push, pop, empty;
  logic [7:0]    head;

  state_t        state_reg, state_next;
  logic [3:0]    k_reg, k_next;
  logic [7:0]    cur_reg, cur_next;

  assign push      = png_valid & png_ready_reg;
  assign empty     = (count_reg == '0);
  assign head      = mem[rd_ptr_reg];
  assign png_ready = png_ready_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= png_pixel;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      png_ready_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg     <= count_next;
      png_ready_reg <= (count_next != DEPTH_C);
    end
  end

`ifdef PNG_TO_BINARY_INTERP_EN
  logic [7:0] prev_reg, prev_next;
  logic       first_reg, first_next;
  logic [7:0] pix_reg;
`endif

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    cur_next   = cur_reg;
    pop        = 1'b0;
`ifdef PNG_TO_BINARY_INTERP_EN
    prev_next  = prev_reg;
    first_next = first_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cur_next   = head;
          k_next     = 4'd1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (binary_ready) begin
          if (k_reg < KMAX) begin
            k_next = k_reg + 4'd1;
          end else begin
`ifdef PNG_TO_BINARY_INTERP_EN
            prev_next  = cur_reg;
            first_next = 1'b0;
`endif
            // Chain straight into the next group when a sample is waiting.
            if (!empty) begin
              pop      = 1'b1;
              cur_next = head;
              k_next   = 4'd1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      cur_reg   <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      cur_reg   <= cur_next;
    end
  end

  assign binary_valid = (state_reg == EMIT);

`ifdef PNG_TO_BINARY_INTERP_EN
  function automatic logic [7:0] interp(input logic [7:0] p, input logic [7:0] c,
                                        input logic [3:0] k);
    logic [11:0] acc;
    acc = 12'(KMAX - k) * 12'(p) + 12'(k) * 12'(c);
    return 8'(acc / 12'(REPEAT));
  endfunction

  // The output is computed from next-state values so it lines up with k.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_reg  <= '0;
      first_reg <= 1'b1;
      pix_reg   <= '0;
    end else begin
      prev_reg  <= prev_next;
      first_reg <= first_next;
      pix_reg   <= interp(first_next ? cur_next : prev_next, cur_next, k_next);
    end
  end

  assign binary_pixel = pix_reg;
`else
  assign binary_pixel = cur_reg;
`endif

endmodule
